// File: rtl/lrn_window_buffer.sv
// lrn_window_buffer
// Receive-side column buffer for local response normalisation. It captures one
// channel column from feature-map memory and squares each pixel as it arrives.
// It then streams one (pixel, windowed sum of squares) pair per channel over a
// valid/ready handshake. A one-cycle normalized_window pulse marks the end of a
// column, after which the block re-arms for the next one.
//
// Ports
//   core_clk, reset      : clock, asynchronous active-high reset
//   dim3                 : channels in the current column (held during a column)
//   mem_rd_data/_valid   : incoming pixel stream
//   full_flag            : column captured, held until normalized_window
//   out_valid/out_ready  : output handshake
//   out_pixel            : x[c]
//   out_sum_sq           : sum of x[k]^2 over the LRN window clipped to [0, dim3-1]
//   out_last             : current pair is channel dim3-1
//   normalized_window    : one-cycle pulse after the last pair is accepted
//   drop_err             : sticky, a write was discarded
module lrn_window_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int M_WIDTH    = 10,
    parameter int DEPTH      = 64,
    parameter int LOCAL_SIZE = 5,
    parameter int SUM_WIDTH  = 35
) (
    input  logic                  core_clk,
    input  logic                  reset,
    input  logic [M_WIDTH-1:0]    dim3,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    input  logic                  mem_rd_valid,
    output logic                  full_flag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_pixel,
    output logic [SUM_WIDTH-1:0]  out_sum_sq,
    output logic                  out_last,
    output logic                  normalized_window,
    output logic                  drop_err
);
    localparam int HALF = (LOCAL_SIZE - 1) / 2;
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SQW  = 2 * DATA_WIDTH;
    // Index arithmetic is done two bits wider than dim3 so c+1+HALF never wraps.
    localparam int IW   = M_WIDTH + 2;
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);
    localparam logic [IW-1:0] IDX_TWO  = IW'(2);
    localparam logic [IW-1:0] IDX_HALF = IW'(HALF);
    localparam logic [IW-1:0] IDX_HP1  = IW'(HALF + 1);
    localparam logic [IW-1:0] IDX_DEP  = IW'(DEPTH);

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_PRIME = 2'd1,
        S_EMIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [M_WIDTH-1:0]    wr_cnt_q, wr_cnt_d;
    logic [M_WIDTH-1:0]    k_q, k_d;
    logic [M_WIDTH-1:0]    c_q, c_d;
    logic [SUM_WIDTH-1:0]  acc_q, acc_d;
    logic                  full_q, full_d;
    logic                  valid_q, valid_d;
    logic                  last_q, last_d;
    logic                  norm_q, norm_d;
    logic                  drop_q, drop_d;
    logic [DATA_WIDTH-1:0] pixel_q, pixel_d;

    logic [DATA_WIDTH-1:0] pix_q [DEPTH];
    logic [SQW-1:0]        sq_q  [DEPTH];

    logic [IW-1:0]         dim3_x_s, wr_x_s, k_x_s, c_x_s;
    logic [IW-1:0]         add_idx_s, sub_idx_s, nxt_idx_s, prime_len_s;
    logic                  dim3_nz_s, wr_ok_s, fill_done_s, prime_last_s, hs_s;
    logic                  add_ok_s, sub_ok_s, nxt_ok_s, k_ok_s, last_next_s;
    logic [SQW-1:0]        sq_wr_s, sq_k_s, sq_add_s, sq_sub_s;
    logic [DATA_WIDTH-1:0] pix_first_s, pix_next_s;

    assign dim3_x_s  = IW'(dim3);
    assign wr_x_s    = IW'(wr_cnt_q);
    assign k_x_s     = IW'(k_q);
    assign c_x_s     = IW'(c_q);
    assign dim3_nz_s = (dim3 != {M_WIDTH{1'b0}});

    // A fill write is stored only while it fits; dropped writes still count.
    assign wr_ok_s     = (state_q == S_FILL) && mem_rd_valid && dim3_nz_s && (wr_x_s < IDX_DEP);
    assign fill_done_s = (state_q == S_FILL) && mem_rd_valid && dim3_nz_s
                         && ((wr_x_s + IDX_ONE) == dim3_x_s);
    assign sq_wr_s     = SQW'(mem_rd_data) * SQW'(mem_rd_data);

    // Priming preloads the window for c = 0, i.e. channels 0 .. min(HALF, dim3-1).
    assign prime_len_s  = (dim3_x_s < IDX_HP1) ? dim3_x_s : IDX_HP1;
    assign prime_last_s = ((k_x_s + IDX_ONE) == prime_len_s);
    assign hs_s         = (state_q == S_EMIT) && valid_q && out_ready;

    // Sliding window: entering channel c+1+HALF, leaving channel c-HALF.
    assign add_idx_s   = c_x_s + IDX_HP1;
    assign sub_idx_s   = c_x_s - IDX_HALF;
    assign nxt_idx_s   = c_x_s + IDX_ONE;
    assign add_ok_s    = (add_idx_s < dim3_x_s) && (add_idx_s < IDX_DEP);
    assign sub_ok_s    = (c_x_s >= IDX_HALF) && (sub_idx_s < IDX_DEP);
    assign nxt_ok_s    = (nxt_idx_s < IDX_DEP);
    assign k_ok_s      = (k_x_s < IDX_DEP);
    assign last_next_s = ((c_x_s + IDX_TWO) == dim3_x_s);

    // Entries beyond DEPTH were never stored and read as zero.
    assign sq_k_s      = k_ok_s   ? sq_q[k_q[AW-1:0]]         : {SQW{1'b0}};
    assign sq_add_s    = add_ok_s ? sq_q[add_idx_s[AW-1:0]]   : {SQW{1'b0}};
    assign sq_sub_s    = sub_ok_s ? sq_q[sub_idx_s[AW-1:0]]   : {SQW{1'b0}};
    assign pix_next_s  = nxt_ok_s ? pix_q[nxt_idx_s[AW-1:0]]  : {DATA_WIDTH{1'b0}};
    assign pix_first_s = pix_q[{AW{1'b0}}];

    // Column buffer write port; contents need no reset.
    always_ff @(posedge core_clk) begin
        if (wr_ok_s) begin
            pix_q[wr_cnt_q[AW-1:0]] <= mem_rd_data;
            sq_q[wr_cnt_q[AW-1:0]]  <= sq_wr_s;
        end
    end

    // State register.
    always_ff @(posedge core_clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FILL:  if (fill_done_s)           state_d = S_PRIME; else state_d = S_FILL;
            S_PRIME: if (prime_last_s)          state_d = S_EMIT;  else state_d = S_PRIME;
            S_EMIT:  if (hs_s && last_q)        state_d = S_DONE;  else state_d = S_EMIT;
            S_DONE:                             state_d = S_FILL;
            default:                            state_d = S_FILL;
        endcase
    end

    // Next values of counters, accumulator and registered outputs.
    always_comb begin
        wr_cnt_d = wr_cnt_q;
        k_d      = k_q;
        c_d      = c_q;
        acc_d    = acc_q;
        full_d   = full_q;
        valid_d  = valid_q;
        last_d   = last_q;
        pixel_d  = pixel_q;
        norm_d   = 1'b0;
        drop_d   = drop_q | (mem_rd_valid & ~wr_ok_s);
        case (state_q)
            S_FILL: begin
                if (mem_rd_valid) begin
                    wr_cnt_d = wr_cnt_q + {{(M_WIDTH-1){1'b0}}, 1'b1};
                end else begin
                    wr_cnt_d = wr_cnt_q;
                end
                if (fill_done_s) begin
                    full_d = 1'b1;
                    acc_d  = {SUM_WIDTH{1'b0}};
                    k_d    = {M_WIDTH{1'b0}};
                end else begin
                    full_d = full_q;
                end
            end
            S_PRIME: begin
                acc_d = acc_q + SUM_WIDTH'(sq_k_s);
                k_d   = k_q + {{(M_WIDTH-1){1'b0}}, 1'b1};
                if (prime_last_s) begin
                    c_d     = {M_WIDTH{1'b0}};
                    pixel_d = pix_first_s;
                    valid_d = 1'b1;
                    last_d  = (dim3_x_s == IDX_ONE);
                end else begin
                    valid_d = valid_q;
                end
            end
            S_EMIT: begin
                if (hs_s && last_q) begin
                    // Column complete: the DONE cycle already shows the cleared state.
                    valid_d  = 1'b0;
                    last_d   = 1'b0;
                    norm_d   = 1'b1;
                    full_d   = 1'b0;
                    wr_cnt_d = {M_WIDTH{1'b0}};
                    acc_d    = {SUM_WIDTH{1'b0}};
                end else if (hs_s) begin
                    // The removed term was added earlier, so this never underflows.
                    acc_d   = acc_q + SUM_WIDTH'(sq_add_s) - SUM_WIDTH'(sq_sub_s);
                    c_d     = c_q + {{(M_WIDTH-1){1'b0}}, 1'b1};
                    pixel_d = pix_next_s;
                    last_d  = last_next_s;
                end else begin
                    acc_d = acc_q;
                end
            end
            S_DONE: begin
                full_d   = 1'b0;
                wr_cnt_d = {M_WIDTH{1'b0}};
                acc_d    = {SUM_WIDTH{1'b0}};
            end
            default: begin
                valid_d = 1'b0;
            end
        endcase
    end

    // Counters, accumulator and registered outputs.
    always_ff @(posedge core_clk or posedge reset) begin
        if (reset) begin
            wr_cnt_q <= {M_WIDTH{1'b0}};
            k_q      <= {M_WIDTH{1'b0}};
            c_q      <= {M_WIDTH{1'b0}};
            acc_q    <= {SUM_WIDTH{1'b0}};
            full_q   <= 1'b0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            pixel_q  <= {DATA_WIDTH{1'b0}};
            norm_q   <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            wr_cnt_q <= wr_cnt_d;
            k_q      <= k_d;
            c_q      <= c_d;
            acc_q    <= acc_d;
            full_q   <= full_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            pixel_q  <= pixel_d;
            norm_q   <= norm_d;
            drop_q   <= drop_d;
        end
    end

    assign full_flag         = full_q;
    assign out_valid         = valid_q;
    assign out_pixel         = pixel_q;
    assign out_sum_sq        = acc_q;
    assign out_last          = last_q;
    assign normalized_window = norm_q;
    assign drop_err          = drop_q;

endmodule

// File: tb/tb_lrn_window_buffer.sv
// Scoreboard bench for lrn_window_buffer (LOCAL_SIZE=3, DEPTH=64).
// Expected pairs are computed from the column data when a column is issued and
// queued; a monitor on the falling edge compares and pops on each handshake.
module tb_lrn_window_buffer;
    localparam int DW    = 16;
    localparam int MW    = 10;
    localparam int DEPTH = 64;
    localparam int LS    = 3;
    localparam int SW    = 35;
    localparam int HALF  = (LS - 1) / 2;

    logic          core_clk;
    logic          reset;
    logic [MW-1:0] dim3;
    logic [DW-1:0] mem_rd_data;
    logic          mem_rd_valid;
    logic          full_flag;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_pixel;
    logic [SW-1:0] out_sum_sq;
    logic          out_last;
    logic          normalized_window;
    logic          drop_err;

    typedef struct {
        logic [DW-1:0] pix;
        logic [SW-1:0] sum;
        logic          last;
        logic          chk;
    } exp_t;

    exp_t        exp_q[$];
    int          checks     = 0;
    int          errors     = 0;
    int          hs_count   = 0;
    int          done_count = 0;
    int unsigned col_data [128];

    lrn_window_buffer #(
        .DATA_WIDTH (DW),
        .M_WIDTH    (MW),
        .DEPTH      (DEPTH),
        .LOCAL_SIZE (LS),
        .SUM_WIDTH  (SW)
    ) dut (
        .core_clk          (core_clk),
        .reset             (reset),
        .dim3              (dim3),
        .mem_rd_data       (mem_rd_data),
        .mem_rd_valid      (mem_rd_valid),
        .full_flag         (full_flag),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_pixel         (out_pixel),
        .out_sum_sq        (out_sum_sq),
        .out_last          (out_last),
        .normalized_window (normalized_window),
        .drop_err          (drop_err)
    );

    initial begin
        core_clk = 1'b0;
        forever #5 core_clk = ~core_clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_full"},  64'(full_flag),         64'd0);
        check({tag, "_valid"}, 64'(out_valid),         64'd0);
        check({tag, "_pixel"}, 64'(out_pixel),         64'd0);
        check({tag, "_sum"},   64'(out_sum_sq),        64'd0);
        check({tag, "_last"},  64'(out_last),          64'd0);
        check({tag, "_norm"},  64'(normalized_window), 64'd0);
        check({tag, "_drop"},  64'(drop_err),          64'd0);
    endtask

    // Reference: clipped window sum of squares straight from the definition.
    function automatic void push_expected(input int n);
        for (int c = 0; c < n; c++) begin
            exp_t            e;
            longint unsigned s;
            s     = 64'd0;
            e.chk = 1'b1;
            for (int k = c - HALF; k <= c + HALF; k++) begin
                if (k >= 0 && k < n) begin
                    if (k >= DEPTH) e.chk = 1'b0;
                    s += 64'(col_data[k]) * 64'(col_data[k]);
                end
            end
            if (c >= DEPTH) e.chk = 1'b0;
            e.pix  = DW'(col_data[c]);
            e.sum  = SW'(s);
            e.last = (c == n - 1);
            exp_q.push_back(e);
        end
    endfunction

    // Monitor: compares the presented pair with the queue head every cycle.
    initial begin : monitor
        exp_t e;
        logic norm_pending;
        norm_pending = 1'b0;
        forever begin
            @(negedge core_clk);
            if (reset) begin
                norm_pending = 1'b0;
            end else begin
                if (norm_pending) begin
                    check("norm_pulse", 64'(normalized_window), 64'd1);
                    check("full_clear", 64'(full_flag), 64'd0);
                    norm_pending = 1'b0;
                end else if (normalized_window) begin
                    check("norm_unexpected", 64'(normalized_window), 64'd0);
                end
                if (normalized_window) done_count++;
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        check("valid_unexpected", 64'(out_valid), 64'd0);
                    end else begin
                        e = exp_q[0];
                        check("last", 64'(out_last), 64'(e.last));
                        if (e.chk) begin
                            check("pixel",  64'(out_pixel),  64'(e.pix));
                            check("sum_sq", 64'(out_sum_sq), 64'(e.sum));
                        end
                        if (out_ready) begin
                            void'(exp_q.pop_front());
                            hs_count++;
                            if (e.last) norm_pending = 1'b1;
                        end
                    end
                end
            end
        end
    end

    task automatic set_seq(input int n);
        for (int i = 0; i < n; i++) col_data[i] = i + 1;
    endtask

    task automatic run_fill(input int n, input bit gaps, input bit track_drop);
        int p;
        push_expected(n);
        dim3 = MW'(n);
        for (int i = 0; i < n; i++) begin
            if (gaps && ($urandom_range(0, 3) == 0)) begin
                @(posedge core_clk); #1;
            end
            if (i == n - 1) check("full_pre", 64'(full_flag), 64'd0);
            mem_rd_valid = 1'b1;
            mem_rd_data  = DW'(col_data[i]);
            @(posedge core_clk); #1;
            mem_rd_valid = 1'b0;
            if (track_drop) check("drop_track", 64'(drop_err), 64'(i >= DEPTH));
        end
        check("full_rise", 64'(full_flag), 64'd1);
        p = (n < HALF + 1) ? n : HALF + 1;
        for (int j = 0; j < p; j++) begin
            check("valid_early", 64'(out_valid), 64'd0);
            @(posedge core_clk); #1;
        end
        check("valid_rise", 64'(out_valid), 64'd1);
    endtask

    // mode 0: ready=1, 1: random ready, 2: stall 4 cycles at pair 'at',
    // 3: illegal write at pair 'at', 4: reset at pair 'at'.
    task automatic run_drain(input int mode, input int at, output int vc);
        int hs_base, done_base, budget, stall_left, rel;
        bit injected, drop_chk;
        hs_base    = hs_count;
        done_base  = done_count;
        budget     = 2000;
        stall_left = 4;
        injected   = 1'b0;
        drop_chk   = 1'b0;
        vc         = 0;
        while (done_count == done_base) begin
            if (budget == 0) begin
                check("drain_timeout", 64'(done_count - done_base), 64'd1);
                break;
            end
            if (out_valid) vc++;
            rel = hs_count - hs_base;
            if (mode == 4 && rel == at) begin
                reset = 1'b1;
                #1;
                check_zero("reset_mid");
                exp_q.delete();
                @(posedge core_clk); #1;
                reset     = 1'b0;
                out_ready = 1'b1;
                return;
            end
            case (mode)
                1: out_ready = ($urandom_range(0, 3) != 0);
                2: begin
                    if (rel == at && stall_left > 0) begin
                        out_ready = 1'b0;
                        stall_left--;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
                default: out_ready = 1'b1;
            endcase
            if (mode == 3 && !injected && rel == at) begin
                check("drop_pre", 64'(drop_err), 64'd0);
                mem_rd_valid = 1'b1;
                mem_rd_data  = DW'($urandom);
                injected     = 1'b1;
                drop_chk     = 1'b1;
            end
            @(posedge core_clk); #1;
            budget--;
            if (drop_chk) begin
                mem_rd_valid = 1'b0;
                check("drop_rise", 64'(drop_err), 64'd1);
                drop_chk = 1'b0;
            end
        end
    endtask

    initial begin : stimulus
        int vc;
        int n;
        reset        = 1'b1;
        mem_rd_valid = 1'b0;
        mem_rd_data  = '0;
        out_ready    = 1'b0;
        dim3         = '0;
        repeat (3) @(posedge core_clk);
        #1;
        check_zero("reset");
        reset = 1'b0;
        @(posedge core_clk); #1;

        // Basic window: 1..5 gives (1,5) (2,14) (3,29) (4,50) (5,41).
        set_seq(5);
        run_fill(5, 1'b0, 1'b0);
        run_drain(0, 0, vc);
        check("emit_cycles_basic", 64'(vc), 64'd5);

        // Single channel, issued back-to-back.
        col_data[0] = 7;
        run_fill(1, 1'b0, 1'b0);
        run_drain(0, 0, vc);
        check("emit_cycles_single", 64'(vc), 64'd1);

        // Backpressure: 4 stall cycles at c=2.
        set_seq(5);
        run_fill(5, 1'b0, 1'b0);
        run_drain(2, 2, vc);
        check("emit_cycles_stall", 64'(vc), 64'd9);

        // Random back-to-back columns with random gaps and ready.
        for (int t = 0; t < 6; t++) begin
            n = $urandom_range(1, 20);
            for (int i = 0; i < n; i++) col_data[i] = $urandom_range(0, 65535);
            run_fill(n, 1'b1, 1'b0);
            run_drain(1, 0, vc);
        end
        check("drop_clean", 64'(drop_err), 64'd0);

        // Illegal write during EMIT.
        set_seq(5);
        run_fill(5, 1'b0, 1'b0);
        run_drain(3, 1, vc);
        check("emit_cycles_illegal", 64'(vc), 64'd5);
        check("drop_sticky", 64'(drop_err), 64'd1);

        // Reset mid-EMIT, then a fresh basic column.
        set_seq(5);
        run_fill(5, 1'b0, 1'b0);
        run_drain(4, 2, vc);
        set_seq(5);
        run_fill(5, 1'b0, 1'b0);
        run_drain(0, 0, vc);
        check("emit_cycles_after_reset", 64'(vc), 64'd5);

        // Overflow: dim3=66 with DEPTH=64.
        for (int i = 0; i < 66; i++) col_data[i] = $urandom_range(0, 65535);
        run_fill(66, 1'b0, 1'b1);
        run_drain(0, 0, vc);
        check("emit_cycles_overflow", 64'(vc), 64'd66);
        check("drop_overflow", 64'(drop_err), 64'd1);

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
